// File: rtl/floor_request_manager.sv
// floor_request_manager: latches hall/cabin calls, assigns hall calls to the
// nearer car, and runs a per-car door dwell FSM that clears served floors.
// Macro DOOR_HOLD_EN: a cabin press at the dwell floor re-holds the door.
// Ports: clk, rst (async, active low), simState (0 START 1 SIM 2 PAUSE
// 3 ENDING), hall_call[5:0], cabin_call[11:0] ([11:6] left, [5:0] right),
// half_elevatorPositions[7:0] ([3:0] left), directions[1:0] (1 = up),
// FloorsRequested/FloorDestinations[11:0] ([11:6] left), door_open[1:0].
module floor_request_manager #(
  parameter int unsigned DWELL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  simState,
  input  logic [5:0]  hall_call,
  input  logic [11:0] cabin_call,
  input  logic [7:0]  half_elevatorPositions,
  input  logic [1:0]  directions,
  output logic [11:0] FloorsRequested,
  output logic [11:0] FloorDestinations,
  output logic [1:0]  door_open
);

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_SIM   = 2'd1;
  localparam logic [7:0] DWELL_LD = 8'(DWELL_CYCLES - 1);

  typedef enum logic {TRACK, DWELL} state_e;

  // Index 0 = left car, 1 = right car throughout.
  state_e          st_q  [2];
  state_e          st_d  [2];
  logic [7:0]      cnt_q [2];
  logic [7:0]      cnt_d [2];
  logic [2:0]      flr_q [2];
  logic [2:0]      flr_d [2];
  logic [1:0][5:0] req_q, req_d;
  logic [1:0][5:0] dst_q, dst_d;
  logic [1:0][5:0] new_req, new_dst;
  logic [1:0][5:0] drop;
  logic [1:0][5:0] cab;
  logic [3:0]      pos   [2];
  logic [2:0]      af    [2];
  logic [1:0]      at;

  assign cab = {cabin_call[5:0], cabin_call[11:6]};

  always_comb begin
    pos[0] = half_elevatorPositions[3:0];
    pos[1] = half_elevatorPositions[7:4];
    for (int k = 0; k < 2; k++) begin
      at[k] = !pos[k][0] && (pos[k] <= 4'd10);
      af[k] = pos[k][3:1];
    end
  end

  // Hall-call assignment and press filtering.
  always_comb begin
    logic [3:0] tgt, dl, dr;
    logic       el_l, el_r, tw_l, tw_r, pick_r;
    tgt     = '0;
    dl      = '0;
    dr      = '0;
    el_l    = 1'b0;
    el_r    = 1'b0;
    tw_l    = 1'b0;
    tw_r    = 1'b0;
    pick_r  = 1'b0;
    new_req = '0;
    for (int k = 0; k < 2; k++) begin
      // A press for the floor a car is dwelling at is already served.
      drop[k] = (st_q[k] == DWELL) ? (6'b000001 << flr_q[k]) : 6'b0;
    end
    el_l = pos[0] <= 4'd10;
    el_r = pos[1] <= 4'd10;
    for (int f = 0; f < 6; f++) begin
      tgt  = 4'(2 * f);
      dl   = (tgt >= pos[0]) ? tgt - pos[0] : pos[0] - tgt;
      dr   = (tgt >= pos[1]) ? tgt - pos[1] : pos[1] - tgt;
      tw_l = directions[0] ? (tgt > pos[0]) : (tgt < pos[0]);
      tw_r = directions[1] ? (tgt > pos[1]) : (tgt < pos[1]);
      // Left wins every unresolved tie, including both cars ineligible.
      pick_r = el_r && (!el_l || (dr < dl) ||
               ((dr == dl) && tw_r && !tw_l));
      if (hall_call[f] && !req_q[0][f] && !req_q[1][f]) begin
        if (pick_r) new_req[1][f] = 1'b1;
        else        new_req[0][f] = 1'b1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      new_req[k] = new_req[k] & ~drop[k];
      new_dst[k] = cab[k] & ~drop[k];
    end
  end

  // Next state: request latches and dwell FSMs.
  always_comb begin
    req_d = req_q;
    dst_d = dst_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    flr_d = flr_q;
    if (simState == ST_START) begin
      req_d = '0;
      dst_d = '0;
      for (int k = 0; k < 2; k++) begin
        st_d[k]  = TRACK;
        cnt_d[k] = '0;
        flr_d[k] = '0;
      end
    end else if (simState == ST_SIM) begin
      req_d = req_q | new_req;
      dst_d = dst_q | new_dst;
      for (int k = 0; k < 2; k++) begin
        if (st_q[k] == TRACK) begin
          if (at[k] && (req_q[k][af[k]] || dst_q[k][af[k]])) begin
            st_d[k]  = DWELL;
            cnt_d[k] = DWELL_LD;
            flr_d[k] = af[k];
          end
        end else begin
`ifdef DOOR_HOLD_EN
          if (cab[k][flr_q[k]]) begin
            cnt_d[k] = DWELL_LD;
          end else
`endif
          if (cnt_q[k] == 8'd0) begin
            req_d[k][flr_q[k]] = 1'b0;
            dst_d[k][flr_q[k]] = 1'b0;
            st_d[k]            = TRACK;
          end else begin
            cnt_d[k] = cnt_q[k] - 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
      dst_q <= '0;
      for (int k = 0; k < 2; k++) begin
        st_q[k]  <= TRACK;
        cnt_q[k] <= '0;
        flr_q[k] <= '0;
      end
    end else begin
      req_q <= req_d;
      dst_q <= dst_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
      flr_q <= flr_d;
    end
  end

  assign FloorsRequested   = {req_q[0], req_q[1]};
  assign FloorDestinations = {dst_q[0], dst_q[1]};
  assign door_open         = {st_q[1] == DWELL, st_q[0] == DWELL};

endmodule

// File: tb/tb_floor_request_manager.sv
// tb_floor_request_manager: directed vectors for floor_request_manager.
// Checks hall assignment, cabin latching, dwell timing, pause and reset.
module tb_floor_request_manager;

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_SIM   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;
`ifdef DOOR_HOLD_EN
  localparam int HOLD_N = 14;
`else
  localparam int HOLD_N = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  simState;
  logic [5:0]  hall_call;
  logic [11:0] cabin_call;
  logic [7:0]  pos;
  logic [1:0]  directions;
  logic [11:0] FloorsRequested;
  logic [11:0] FloorDestinations;
  logic [1:0]  door_open;

  int n_chk  = 0;
  int n_pass = 0;
  int n;

  floor_request_manager #(.DWELL_CYCLES(8)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .simState               (simState),
    .hall_call              (hall_call),
    .cabin_call             (cabin_call),
    .half_elevatorPositions (pos),
    .directions             (directions),
    .FloorsRequested        (FloorsRequested),
    .FloorDestinations      (FloorDestinations),
    .door_open              (door_open)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] got,
                     input logic [11:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b", tag, got, exp);
  endtask

  // Count sampled door-open cycles of one car, with optional pause/press.
  task automatic run_dwell(input int car, input int pause_at,
                           input int press_at, input logic [11:0] press,
                           output int cnt);
    int pl;
    cnt = 0;
    pl  = 0;
    for (int i = 0; i < 60; i++) begin
      if (door_open[car] !== 1'b1) break;
      cnt++;
      cabin_call = (cnt == press_at) ? press : 12'b0;
      if (cnt == pause_at) pl = 5;
      simState = (pl > 0) ? S_PAUSE : S_SIM;
      if (pl > 0) pl--;
      tick();
    end
    cabin_call = '0;
    simState   = S_SIM;
  endtask

  task automatic press_hall(input logic [5:0] h);
    hall_call = h;
    tick();
    hall_call = '0;
  endtask

  task automatic do_start();
    simState = S_START;
    tick();
    simState = S_SIM;
  endtask

  initial begin
    rst = 1'b0;
    simState = S_START;
    hall_call = '0;
    cabin_call = '0;
    pos = '0;
    directions = '0;
    #3;
    chk("rst_req", FloorsRequested, 12'b0);
    chk("rst_dst", FloorDestinations, 12'b0);
    chk("rst_door", {10'b0, door_open}, 12'b0);
    rst = 1'b1;
    simState = S_SIM;
    pos = {4'd10, 4'd0};
    tick();

    // Floor 2: left distance 4, right distance 6.
    press_hall(6'b000100);
    chk("hall_near", FloorsRequested, 12'b000100_000000);

    // Floor 3 with cars off-floor: left 5, right 3.
    pos = {4'd9, 4'd1};
    press_hall(6'b001000);
    chk("hall_far", FloorsRequested, 12'b000100_001000);

    simState = S_END;
    hall_call = 6'b100000;
    cabin_call = 12'hFFF;
    tick();
    simState = S_PAUSE;
    tick();
    hall_call = '0;
    cabin_call = '0;
    chk("hold_req", FloorsRequested, 12'b000100_001000);
    chk("hold_dst", FloorDestinations, 12'b0);
    simState = S_SIM;

    do_start();
    chk("start_clr", FloorsRequested, 12'b0);

    // Tie at distance 2, both pointing toward floor 3: left.
    pos = {4'd8, 4'd4};
    directions = 2'b01;
    press_hall(6'b001000);
    chk("tie_left", FloorsRequested, 12'b001000_000000);

    // Tie, only right points toward floor 3: right.
    do_start();
    directions = 2'b00;
    press_hall(6'b001000);
    chk("tie_dir", FloorsRequested, 12'b000000_001000);

    // Left above top floor is ineligible.
    pos = {4'd8, 4'd12};
    press_hall(6'b000001);
    chk("inelig", FloorsRequested, 12'b000000_001001);

    // Floor 3 already held by right: no second assignment.
    pos = {4'd9, 4'd6};
    press_hall(6'b001000);
    chk("held", FloorsRequested, 12'b000000_001001);

    // Same-cycle hall and cabin press for floor 5.
    do_start();
    pos = {4'd9, 4'd1};
    hall_call = 6'b100000;
    cabin_call = 12'b100000_000000;
    tick();
    hall_call = '0;
    cabin_call = '0;
    chk("same_req", FloorsRequested, 12'b000000_100000);
    chk("same_dst", FloorDestinations, 12'b100000_000000);

    // Left destination floor 2, arrival, dwell with a press at count 2.
    do_start();
    cabin_call = 12'b000100_000000;
    tick();
    cabin_call = '0;
    chk("cab_latch", FloorDestinations, 12'b000100_000000);
    pos = {4'd9, 4'd4};
    tick();
    chk("arrive", {10'b0, door_open}, 12'b01);
    run_dwell(0, 0, 6, 12'b000100_000000, n);
    chk("dwell_len", 12'(n), 12'(HOLD_N));
    chk("dwell_dst", FloorDestinations, 12'b0);
    chk("dwell_door", {10'b0, door_open}, 12'b0);

    // Dwell at floor 3 with a 5-cycle pause: 13 open cycles.
    cabin_call = 12'b001000_000000;
    tick();
    cabin_call = '0;
    pos = {4'd9, 4'd6};
    tick();
    chk("arrive2", {10'b0, door_open}, 12'b01);
    run_dwell(0, 2, 0, 12'b0, n);
    chk("pause_len", 12'(n), 12'd13);
    chk("pause_dst", FloorDestinations, 12'b0);

    // Both cars dwelling, asynchronous reset mid-dwell.
    do_start();
    pos = {4'd9, 4'd1};
    hall_call = 6'b010000;
    cabin_call = 12'b000100_000000;
    tick();
    hall_call = '0;
    cabin_call = '0;
    chk("pend_req", FloorsRequested, 12'b000000_010000);
    pos = {4'd8, 4'd4};
    tick();
    chk("both_door", {10'b0, door_open}, 12'b11);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_req", FloorsRequested, 12'b0);
    chk("arst_dst", FloorDestinations, 12'b0);
    chk("arst_door", {10'b0, door_open}, 12'b0);
    #2 rst = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst", {10'b0, door_open}, 12'b0);
    cabin_call = 12'b000010_000000;
    tick();
    cabin_call = '0;
    pos = {4'd8, 4'd2};
    tick();
    chk("new_arr", {10'b0, door_open}, 12'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
